// File: rtl/pack_arbiter_2to1.sv
// pack_arbiter_2to1: 2:1 arbiter forwarding 16-beat groups of 24-bit beats to a 24-to-128 packer.
// Build option PAD_TIMEOUT_EN: a group stalled for 8 cycles is completed with zero pad beats.
module pack_arbiter_2to1 #(
   parameter int DATA_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s0_valid,
   output logic              s0_ready,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              s1_valid,
   output logic              s1_ready,
   output logic [DATA_W-1:0] pk_data,
   output logic              pk_valid,
   output logic              pk_src,
   output logic              pk_pad,
   output logic              grp_done
);

   localparam logic [3:0] LAST_BEAT = 4'd15;

`ifdef PAD_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, PAD = 2'd2} state_t;
   localparam logic [2:0] STALL_MAX = 3'd7;
   logic [2:0] stall_cnt;
   logic       pad_q;
   assign pk_pad = pad_q;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
   assign pk_pad = 1'b0;
`endif

   state_t            state;
   logic              grant;
   logic              last_grant;
   logic [3:0]        beat_cnt;
   logic              hs;
   logic              last_beat;
   logic [DATA_W-1:0] gnt_data;

   always_comb begin
      hs        = (state == GRANT) && (grant ? s1_valid : s0_valid);
      gnt_data  = grant ? s1_data : s0_data;
      last_beat = (beat_cnt == LAST_BEAT);
   end

   // Ready depends only on registered state, so a source never sees a combinational path.
   assign s0_ready = (state == GRANT) && !grant;
   assign s1_ready = (state == GRANT) &&  grant;
   assign pk_src   = grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         beat_cnt   <= '0;
         pk_data    <= '0;
         pk_valid   <= 1'b0;
         grp_done   <= 1'b0;
`ifdef PAD_TIMEOUT_EN
         stall_cnt  <= '0;
         pad_q      <= 1'b0;
`endif
      end else begin
         pk_valid <= 1'b0;
         grp_done <= 1'b0;
`ifdef PAD_TIMEOUT_EN
         pad_q    <= 1'b0;
`endif
         case (state)
            IDLE: begin
`ifdef PAD_TIMEOUT_EN
               stall_cnt <= '0;
`endif
               // Prefer the source that did not own the previous group.
               if (s0_valid || s1_valid) begin
                  grant <= last_grant ? !s0_valid : s1_valid;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (hs) begin
                  pk_data  <= gnt_data;
                  pk_valid <= 1'b1;
                  beat_cnt <= beat_cnt + 1'b1;
`ifdef PAD_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
                  if (last_beat) begin
                     grp_done   <= 1'b1;
                     last_grant <= grant;
                     state      <= IDLE;
                  end
               end
`ifdef PAD_TIMEOUT_EN
               else if (stall_cnt == STALL_MAX) begin
                  stall_cnt <= '0;
                  state     <= PAD;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
`endif
            end
`ifdef PAD_TIMEOUT_EN
            PAD: begin
               pk_data  <= '0;
               pk_valid <= 1'b1;
               pad_q    <= 1'b1;
               beat_cnt <= beat_cnt + 1'b1;
               if (last_beat) begin
                  grp_done   <= 1'b1;
                  last_grant <= grant;
                  state      <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_one_ready: assert property (@(posedge clk) disable iff (!rst_n) !(s0_ready && s1_ready));
   a_done_beat: assert property (@(posedge clk) disable iff (!rst_n) grp_done |-> pk_valid);
`endif

endmodule

// File: tb/tb_pack_arbiter_2to1.sv
// Randomized bench for pack_arbiter_2to1: per-cycle rule model plus group-level stream checks.
module tb_pack_arbiter_2to1;

`ifdef PAD_TIMEOUT_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] s0_data = '0, s1_data = '0;
   logic        s0_valid = 1'b0, s1_valid = 1'b0;
   logic        s0_ready, s1_ready;
   logic [23:0] pk_data;
   logic        pk_valid, pk_src, pk_pad, grp_done;

   pack_arbiter_2to1 dut (
      .clk(clk), .rst_n(rst_n),
      .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
      .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
      .pk_data(pk_data), .pk_valid(pk_valid), .pk_src(pk_src),
      .pk_pad(pk_pad), .grp_done(grp_done)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   // Model state: phase 0 = between groups, 1 = serving owner, 2 = padding.
   int          m_phase, m_owner, m_last, m_cnt, m_stall;
   logic        exp_valid, exp_done, exp_pad;
   logic [23:0] exp_data;

   logic [23:0] q0[$], q1[$];
   logic [23:0] obs_data[$];
   logic        obs_pad[$];
   int          obs_cyc[$];
   int          grp_src[$];
   int          grp_cyc[$];

   task automatic model_reset();
      m_phase = 0; m_owner = 0; m_last = 1; m_cnt = 0; m_stall = 0;
      exp_valid = 0; exp_done = 0; exp_pad = 0; exp_data = '0;
      obs_data.delete(); obs_pad.delete(); obs_cyc.delete();
      grp_src.delete(); grp_cyc.delete();
   endtask

   // One clock cycle: drive sources, check DUT against model, advance model.
   task automatic step(input bit g0, input bit g1);
      bit          a0, a1, n_valid, n_done, n_pad, own_v, e_r0, e_r1;
      logic [23:0] n_data;
      a0 = 0; a1 = 0;
      s0_valid = g0 && (q0.size() > 0);
      s0_data  = s0_valid ? q0[0] : 24'($urandom);
      s1_valid = g1 && (q1.size() > 0);
      s1_data  = s1_valid ? q1[0] : 24'($urandom);
      @(negedge clk);
      e_r0 = (m_phase == 1) && (m_owner == 0);
      e_r1 = (m_phase == 1) && (m_owner == 1);
      vectors++;
      if (s0_ready !== e_r0) begin errors++; $display("FAIL s0_ready cyc %0d: got %b exp %b", cyc, s0_ready, e_r0); end
      vectors++;
      if (s1_ready !== e_r1) begin errors++; $display("FAIL s1_ready cyc %0d: got %b exp %b", cyc, s1_ready, e_r1); end
      vectors++;
      if (pk_valid !== exp_valid) begin errors++; $display("FAIL pk_valid cyc %0d: got %b exp %b", cyc, pk_valid, exp_valid); end
      vectors++;
      if (grp_done !== exp_done) begin errors++; $display("FAIL grp_done cyc %0d: got %b exp %b", cyc, grp_done, exp_done); end
      vectors++;
      if (pk_pad !== exp_pad) begin errors++; $display("FAIL pk_pad cyc %0d: got %b exp %b", cyc, pk_pad, exp_pad); end
      vectors++;
      if (pk_src !== 1'(m_owner)) begin errors++; $display("FAIL pk_src cyc %0d: got %b exp %0d", cyc, pk_src, m_owner); end
      if (exp_valid) begin
         vectors++;
         if (pk_data !== exp_data) begin errors++; $display("FAIL pk_data cyc %0d: got %h exp %h", cyc, pk_data, exp_data); end
      end
      if (pk_valid === 1'b1) begin obs_data.push_back(pk_data); obs_pad.push_back(pk_pad); obs_cyc.push_back(cyc); end
      if (grp_done === 1'b1) begin grp_src.push_back(int'(pk_src)); grp_cyc.push_back(cyc); end

      n_valid = 0; n_done = 0; n_pad = 0; n_data = exp_data;
      case (m_phase)
         0: if (s0_valid || s1_valid) begin
               if (m_last == 1) m_owner = s0_valid ? 0 : 1;
               else             m_owner = s1_valid ? 1 : 0;
               m_phase = 1; m_stall = 0;
            end
         1: begin
               own_v = (m_owner == 1) ? s1_valid : s0_valid;
               if (own_v) begin
                  n_valid = 1; n_data = (m_owner == 1) ? s1_data : s0_data;
                  if (m_owner == 1) a1 = 1; else a0 = 1;
                  m_cnt++; m_stall = 0;
               end else if (PAD_EN) begin
                  m_stall++;
                  if (m_stall == 8) begin m_phase = 2; m_stall = 0; end
               end
            end
         default: begin n_valid = 1; n_pad = 1; n_data = '0; m_cnt++; end
      endcase
      if (n_valid && m_cnt == 16) begin n_done = 1; m_cnt = 0; m_last = m_owner; m_phase = 0; end

      @(posedge clk); #1; cyc++;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      exp_valid = n_valid; exp_done = n_done; exp_pad = n_pad; exp_data = n_data;
   endtask

   task automatic test_reset();
      rst_n = 0; s0_valid = 0; s1_valid = 0; s0_data = '0; s1_data = '0;
      #3;
      vectors++; if (pk_data  !== 24'h0) begin errors++; $display("FAIL rst pk_data: got %h exp 0", pk_data); end
      vectors++; if (pk_valid !== 1'b0)  begin errors++; $display("FAIL rst pk_valid: got %b exp 0", pk_valid); end
      vectors++; if (pk_pad   !== 1'b0)  begin errors++; $display("FAIL rst pk_pad: got %b exp 0", pk_pad); end
      vectors++; if (grp_done !== 1'b0)  begin errors++; $display("FAIL rst grp_done: got %b exp 0", grp_done); end
      vectors++; if (pk_src   !== 1'b0)  begin errors++; $display("FAIL rst pk_src: got %b exp 0", pk_src); end
      vectors++; if (s0_ready !== 1'b0)  begin errors++; $display("FAIL rst s0_ready: got %b exp 0", s0_ready); end
      vectors++; if (s1_ready !== 1'b0)  begin errors++; $display("FAIL rst s1_ready: got %b exp 0", s1_ready); end
      @(negedge clk); rst_n = 1;
      model_reset(); q0.delete(); q1.delete();
      @(posedge clk); #1; cyc = 0;
   endtask

   task automatic test_single_source();
      int n;
      test_reset();
      for (int i = 1; i <= 16; i++) q0.push_back(24'(i));
      n = 0;
      while (grp_src.size() < 1 && n < 40) begin step(1, 0); n++; end
      vectors++;
      if (grp_src.size() != 1) begin errors++; $display("FAIL single timeout: groups %0d exp 1", grp_src.size()); end
      else begin
         vectors++; if (obs_data.size() != 16) begin errors++; $display("FAIL single beats: got %0d exp 16", obs_data.size()); end
         for (int i = 0; i < 16 && i < obs_data.size(); i++) begin
            vectors++;
            if (obs_data[i] !== 24'(i + 1)) begin errors++; $display("FAIL single data[%0d]: got %h exp %h", i, obs_data[i], 24'(i + 1)); end
         end
         vectors++; if (obs_cyc[0] != 2) begin errors++; $display("FAIL single latency: first beat cyc %0d exp 2", obs_cyc[0]); end
         vectors++; if (grp_cyc[0] != 17) begin errors++; $display("FAIL single done_cyc: got %0d exp 17", grp_cyc[0]); end
         vectors++; if (grp_src[0] != 0) begin errors++; $display("FAIL single src: got %0d exp 0", grp_src[0]); end
      end
   endtask

   task automatic test_alternate();
      int n;
      test_reset();
      for (int i = 0; i < 40; i++) begin q0.push_back(24'($urandom)); q1.push_back(24'($urandom)); end
      n = 0;
      while (grp_src.size() < 4 && n < 120) begin step(1, 1); n++; end
      vectors++;
      if (grp_src.size() != 4) begin errors++; $display("FAIL alt timeout: groups %0d exp 4", grp_src.size()); end
      else begin
         for (int g = 0; g < 4; g++) begin
            vectors++;
            if (grp_src[g] != (g % 2)) begin errors++; $display("FAIL alt owner[%0d]: got %0d exp %0d", g, grp_src[g], g % 2); end
         end
         for (int g = 1; g < 4; g++) begin
            vectors++;
            if (grp_cyc[g] - grp_cyc[g-1] != 17) begin errors++; $display("FAIL alt period[%0d]: got %0d exp 17", g, grp_cyc[g] - grp_cyc[g-1]); end
         end
         vectors++; if (obs_data.size() != 64) begin errors++; $display("FAIL alt beats: got %0d exp 64", obs_data.size()); end
      end
   endtask

   task automatic test_stall_hold();
      logic [23:0] d0[$];
      int n, r1_hi;
      test_reset();
      for (int i = 0; i < 20; i++) begin
         d0.push_back(24'($urandom)); q0.push_back(d0[i]); q1.push_back(24'($urandom));
      end
      n = 0;
      while (m_cnt < 5 && n < 20) begin step(1, 1); n++; end
      r1_hi = 0;
      for (int i = 0; i < 20; i++) begin
         step(0, 1);
         if (s1_ready === 1'b1) r1_hi++;
      end
      vectors++; if (r1_hi != 0) begin errors++; $display("FAIL stall s1_ready: high %0d cycles exp 0", r1_hi); end
      n = 0;
      while (obs_data.size() < 6 && n < 40) begin step(1, 1); n++; end
      vectors++;
      if (obs_data.size() < 6) begin errors++; $display("FAIL stall timeout: beats %0d exp 6", obs_data.size()); end
`ifndef PAD_TIMEOUT_EN
      else begin
         vectors++;
         if (obs_data[5] !== d0[5]) begin errors++; $display("FAIL stall resume: got %h exp %h", obs_data[5], d0[5]); end
      end
`endif
   endtask

`ifdef PAD_TIMEOUT_EN
   task automatic test_pad();
      int n;
      test_reset();
      for (int i = 0; i < 10; i++) q0.push_back(24'($urandom));
      n = 0;
      while (grp_src.size() < 1 && n < 60) begin step(1, 0); n++; end
      vectors++;
      if (grp_src.size() != 1 || obs_data.size() != 16) begin
         errors++; $display("FAIL pad timeout: groups %0d beats %0d exp 1/16", grp_src.size(), obs_data.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            vectors++;
            if (obs_pad[i] !== (i >= 10)) begin errors++; $display("FAIL pad flag[%0d]: got %b exp %b", i, obs_pad[i], i >= 10); end
            if (i >= 10) begin
               vectors++;
               if (obs_data[i] !== 24'h0) begin errors++; $display("FAIL pad data[%0d]: got %h exp 0", i, obs_data[i]); end
            end
         end
         vectors++; if (obs_cyc[10] - obs_cyc[9] != 9) begin errors++; $display("FAIL pad gap: got %0d exp 9", obs_cyc[10] - obs_cyc[9]); end
         vectors++; if (grp_cyc[0] != obs_cyc[15]) begin errors++; $display("FAIL pad done: cyc %0d exp %0d", grp_cyc[0], obs_cyc[15]); end
      end
   endtask
`endif

   task automatic test_mid_reset();
      int n;
      test_reset();
      for (int i = 0; i < 30; i++) begin q0.push_back(24'($urandom)); q1.push_back(24'($urandom)); end
      n = 0;
      while (m_cnt < 9 && n < 20) begin step(1, 1); n++; end
      vectors++; if (grp_src.size() != 0) begin errors++; $display("FAIL midrst early done: got %0d exp 0", grp_src.size()); end
      rst_n = 0; s0_valid = 0; s1_valid = 0;
      #2;
      vectors++; if (pk_valid !== 1'b0) begin errors++; $display("FAIL midrst pk_valid: got %b exp 0", pk_valid); end
      vectors++; if (grp_done !== 1'b0) begin errors++; $display("FAIL midrst grp_done: got %b exp 0", grp_done); end
      vectors++; if (pk_data !== 24'h0) begin errors++; $display("FAIL midrst pk_data: got %h exp 0", pk_data); end
      vectors++; if (s0_ready !== 1'b0) begin errors++; $display("FAIL midrst s0_ready: got %b exp 0", s0_ready); end
      @(negedge clk); rst_n = 1;
      model_reset();
      @(posedge clk); #1; cyc = 0;
      n = 0;
      while (grp_src.size() < 1 && n < 40) begin step(1, 1); n++; end
      vectors++;
      if (grp_src.size() != 1) begin errors++; $display("FAIL midrst timeout: groups %0d exp 1", grp_src.size()); end
      else begin
         vectors++; if (grp_src[0] != 0) begin errors++; $display("FAIL midrst src: got %0d exp 0", grp_src[0]); end
         vectors++; if (obs_data.size() != 16) begin errors++; $display("FAIL midrst beats: got %0d exp 16", obs_data.size()); end
         vectors++; if (grp_cyc[0] != 17) begin errors++; $display("FAIL midrst done_cyc: got %0d exp 17", grp_cyc[0]); end
      end
   endtask

   task automatic test_random();
      test_reset();
      for (int i = 0; i < 600; i++) begin
         if (q0.size() < 4) for (int k = 0; k < 8; k++) q0.push_back(24'($urandom));
         if (q1.size() < 4) for (int k = 0; k < 8; k++) q1.push_back(24'($urandom));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_alternate();
      test_stall_hold();
`ifdef PAD_TIMEOUT_EN
      test_pad();
`endif
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
